u111_word_port_target: RTL and testbench
========================================

Name: u111_word_port_target

Overview:
- Local-bus responder for a 16-bit word port, the terminating side of the 040-to-Amiga cycle/bus-sizing state machine.
- Samples TSn on the Amiga-side local bus and declares PORTSIZE=1 so the initiator splits long-word and line cycles into word cycles.
- Performs single register accesses on a simple backend handshake.
- Terminates with TACKn/TEAn/TBIn on the upper byte lanes (UU/UM) only.

Parameters:
- ADDR_W, 7, width of word-register index taken from A_AMIGA[ADDR_W:1].
- TIMEOUT_CYCLES, 32, CLK40 cycles waiting for REG_ACK before a TEA error termination.
- RO_BASE, 7'h60, first read-only register index; writes at or above it terminate with error.

Ports:
- CLK40  in  1  local bus clock.
- RESETn  in  1  reset, synchronous, active-low.
- TSn  in  1  transfer start from initiator, low for one CLK40.
- SEL  in  1  address-window hit from external decoder, valid with TSn.
- RnW  in  1  1=read.
- SIZ  in  2  00 long, 01 byte, 10 word, 11 line.
- A_AMIGA  in  ADDR_W+1  byte address within window.
- PORTSIZE  out  1  1 while SEL high (word port), else 0.
- TACKn  inout  1  transfer acknowledge, tristate when not owned.
- TEAn  inout  1  transfer error, tristate when not owned.
- TBIn  out  1  burst inhibit, tristate when not owned.
- D_UU_AMIGA  inout  8  data [15:8].
- D_UM_AMIGA  inout  8  data [7:0].
- REG_ADDR  out  ADDR_W  word index.
- REG_WDATA  out  16  write data.
- REG_BE  out  2  byte enables {UU,UM}.
- REG_WE  out  1  write strobe, one cycle.
- REG_RD  out  1  read strobe, one cycle.
- REG_RDATA  in  16  read data, valid with REG_ACK.
- REG_ACK  in  1  backend done.
- REG_BUSY  in  1  backend cannot accept (used only with retry feature).

Behaviour:
- Reset, synchronous on posedge CLK40, RESETn=0:
  - state IDLE; all strobes 0; counters 0.
  - TACKn/TEAn/TBIn/data released to z.
  - Reset mid-cycle aborts at once with no termination driven.
- IDLE: on posedge with TSn=0 and SEL=1, latch RnW, SIZ, A_AMIGA and write lanes; go DECODE. TSn with SEL=0 is ignored.
- DECODE, 1 cycle:
  - compute REG_BE: SIZ=01 with A0=0 gives 10, with A0=1 gives 01; all other sizes give 11.
  - Error if write and index>=RO_BASE, or SIZ=00/11 with A0=1: go TERM with err.
  - Else pulse REG_RD or REG_WE for one cycle, clear timeout counter, go ACCESS.
  - From DECODE onward, drive TACKn=1, TEAn=1, TBIn=0.
- ACCESS: wait for REG_ACK. On ACK, capture REG_RDATA on reads; go TERM ok. If the counter reaches TIMEOUT_CYCLES-1 without ACK, go TERM err. ACK in the same cycle as timeout counts as ok.
- TERM, exactly 1 CLK40:
  - ok: TACKn=0, TEAn=1.
  - err: TACKn=1, TEAn=0.
  - Reads drive the captured data on UU/UM during TERM and RECOVER.
- RECOVER, 1 cycle: drive TACKn=1, TEAn=1, TBIn=1, then release all to z; go IDLE.
- Minimum cycle: TSn sample to TACKn low in 3 CLK40 with zero-wait ACK.
- TBIn is low with every termination, so the initiator never continues a line burst here. Line requests are served as one word each.
- A new TSn arriving in any state other than IDLE is ignored.

Optional Feature:
- Macro U111_TARGET_RETRY_EN.
- Defined: in DECODE, REG_BUSY=1 skips the strobes and goes to TERM with retry (TACKn=0, TEAn=0 for 1 cycle).
- Undefined: REG_BUSY is ignored and a busy backend only delays REG_ACK.

Decomposition:
- Package u111_pkg holds:
  - SIZ encodings (SIZ_LONG/BYTE/WORD/LINE).
  - the termination type constants {TACKn,TEAn}: NORMAL 01, RETRY 00, ERROR 10, WAIT 11.
  - the state enum.
- One natural sub-module, u111_target_lanes: byte-enable generation and data-lane tristate/capture, purely combinational plus capture register.

Test Plan:
- Word read at index 5, backend ACK after 2 cycles returning 16'hBEEF → TACKn low exactly one cycle; UU=8'hBE, UM=8'hEF sampled; TBIn=0, PORTSIZE=1.
- Byte write, SIZ=01, A_AMIGA=8'h0B, UM=8'h5A → REG_BE=01, REG_WE one pulse, REG_WDATA[7:0]=8'h5A, TACKn termination.
- Write to index 7'h61 → no REG_WE; TEAn=0 for one cycle, TACKn=1.
- Read with REG_ACK never asserted → TEAn low at cycle TIMEOUT_CYCLES after strobe; bus released two cycles later.
- RESETn low during ACCESS → TACKn/TEAn/TBIn z next cycle; following TSn served normally.
- With U111_TARGET_RETRY_EN and REG_BUSY=1 at DECODE → TACKn=TEAn=0 for one cycle, no strobes.

Source files
------------

// File: rtl/u111_pkg.sv
// Shared encodings for the u111 word-port bus target.
// SIZ codes, termination pairs {TACKn,TEAn}, FSM states.
package u111_pkg;

  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;
  localparam logic [1:0] SIZ_LINE = 2'b11;

  localparam logic [1:0] TERM_NORMAL = 2'b01;
  localparam logic [1:0] TERM_RETRY  = 2'b00;
  localparam logic [1:0] TERM_ERROR  = 2'b10;
  localparam logic [1:0] TERM_WAIT   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ACCESS,
    ST_TERM,
    ST_RECOVER
  } state_t;

endpackage

// File: rtl/u111_word_port_target_lanes.sv
// Byte-enable generation plus data-lane capture and tristate drive
// for the two upper byte lanes (UU = [15:8], UM = [7:0]).
module u111_target_lanes
  import u111_pkg::*;
(
  input  logic        CLK40,
  input  logic        RESETn,
  input  logic [1:0]  siz,
  input  logic        a0,
  input  logic        wcap,
  input  logic        rcap,
  input  logic        d_oe,
  input  logic [15:0] rdata,
  output logic [1:0]  be,
  output logic [15:0] wdata,
  inout  logic [7:0]  D_UU_AMIGA,
  inout  logic [7:0]  D_UM_AMIGA
);

  logic [15:0] rdata_q;

  // byte cycles pick one lane by A0, everything else is a full word
  always_comb begin
    be = 2'b11;
    if (siz == SIZ_BYTE) be = a0 ? 2'b01 : 2'b10;
  end

  // write lanes latched with the address, read data latched on ACK
  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      wdata   <= '0;
      rdata_q <= '0;
    end else begin
      if (wcap) wdata <= {D_UU_AMIGA, D_UM_AMIGA};
      if (rcap) rdata_q <= rdata;
    end
  end

  assign D_UU_AMIGA = d_oe ? rdata_q[15:8] : 8'bz;
  assign D_UM_AMIGA = d_oe ? rdata_q[7:0]  : 8'bz;

endmodule

// File: rtl/u111_word_port_target.sv
// 16-bit word-port responder on the Amiga-side local bus.
// Build option: U111_TARGET_RETRY_EN turns REG_BUSY into a retry.
module u111_word_port_target
  import u111_pkg::*;
#(
  parameter int                ADDR_W         = 7,
  parameter int                TIMEOUT_CYCLES = 32,
  parameter logic [ADDR_W-1:0] RO_BASE        = 'h60
) (
  input  logic              CLK40,
  input  logic              RESETn,
  input  logic              TSn,
  input  logic              SEL,
  input  logic              RnW,
  input  logic [1:0]        SIZ,
  input  logic [ADDR_W:0]   A_AMIGA,
  output logic              PORTSIZE,
  inout  logic              TACKn,
  inout  logic              TEAn,
  output logic              TBIn,
  inout  logic [7:0]        D_UU_AMIGA,
  inout  logic [7:0]        D_UM_AMIGA,
  output logic [ADDR_W-1:0] REG_ADDR,
  output logic [15:0]       REG_WDATA,
  output logic [1:0]        REG_BE,
  output logic              REG_WE,
  output logic              REG_RD,
  input  logic [15:0]       REG_RDATA,
  input  logic              REG_ACK,
  input  logic              REG_BUSY
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [1:0]        term_q, term_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rnw_q;
  logic [1:0]        siz_q;
  logic [ADDR_W:0]   addr_q;

  logic              cap_w, cap_r, d_oe;
  logic              bus_oe, tack_v, tea_v, tbi_v;
  logic              dec_err;

`ifndef U111_TARGET_RETRY_EN
  logic unused_busy;
  assign unused_busy = REG_BUSY;
`endif

  assign PORTSIZE = SEL;
  assign REG_ADDR = addr_q[ADDR_W:1];

  assign dec_err =
    (!rnw_q && (addr_q[ADDR_W:1] >= RO_BASE)) ||
    (((siz_q == SIZ_LONG) || (siz_q == SIZ_LINE)) && addr_q[0]);

  // request latch, state, termination type and wait counter
  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      state_q <= ST_IDLE;
      term_q  <= TERM_WAIT;
      cnt_q   <= '0;
      rnw_q   <= 1'b1;
      siz_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      term_q  <= term_d;
      cnt_q   <= cnt_d;
      if (cap_w) begin
        rnw_q  <= RnW;
        siz_q  <= SIZ;
        addr_q <= A_AMIGA;
      end
    end
  end

  // next state, strobes and bus drive; counter counts cycles since strobe
  always_comb begin
    state_d = state_q;
    term_d  = term_q;
    cnt_d   = cnt_q;
    cap_w   = 1'b0;
    cap_r   = 1'b0;
    d_oe    = 1'b0;
    REG_RD  = 1'b0;
    REG_WE  = 1'b0;
    bus_oe  = 1'b0;
    tack_v  = 1'b1;
    tea_v   = 1'b1;
    tbi_v   = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (!TSn && SEL) begin
          cap_w   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        bus_oe = 1'b1;
        tbi_v  = 1'b0;
        if (dec_err) begin
          term_d  = TERM_ERROR;
          state_d = ST_TERM;
        end
`ifdef U111_TARGET_RETRY_EN
        else if (REG_BUSY) begin
          term_d  = TERM_RETRY;
          state_d = ST_TERM;
        end
`endif
        else begin
          REG_RD  = rnw_q;
          REG_WE  = !rnw_q;
          cnt_d   = CNT_W'(1);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        bus_oe = 1'b1;
        tbi_v  = 1'b0;
        if (REG_ACK) begin
          cap_r   = rnw_q;
          term_d  = TERM_NORMAL;
          state_d = ST_TERM;
        end else if (cnt_q >= CNT_LAST) begin
          term_d  = TERM_ERROR;
          state_d = ST_TERM;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_TERM: begin
        bus_oe  = 1'b1;
        tbi_v   = 1'b0;
        {tack_v, tea_v} = term_q;
        d_oe    = rnw_q;
        state_d = ST_RECOVER;
      end
      ST_RECOVER: begin
        bus_oe  = 1'b1;
        d_oe    = rnw_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign TACKn = bus_oe ? tack_v : 1'bz;
  assign TEAn  = bus_oe ? tea_v  : 1'bz;
  assign TBIn  = bus_oe ? tbi_v  : 1'bz;

  u111_target_lanes u_lanes (
    .CLK40      (CLK40),
    .RESETn     (RESETn),
    .siz        (siz_q),
    .a0         (addr_q[0]),
    .wcap       (cap_w),
    .rcap       (cap_r),
    .d_oe       (d_oe),
    .rdata      (REG_RDATA),
    .be         (REG_BE),
    .wdata      (REG_WDATA),
    .D_UU_AMIGA (D_UU_AMIGA),
    .D_UM_AMIGA (D_UM_AMIGA)
  );

endmodule

// File: tb/tb_u111_word_port_target.sv
// Scoreboard bench for u111_word_port_target.
// Bus terminations and backend strobes are checked by separate monitors.
module tb_u111_word_port_target;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int T = 32;

  logic        CLK40 = 1'b0;
  logic        RESETn;
  logic        TSn;
  logic        SEL;
  logic        RnW;
  logic [1:0]  SIZ;
  logic [7:0]  A_AMIGA;
  wire         PORTSIZE;
  wire         TACKn;
  wire         TEAn;
  wire         TBIn;
  wire  [7:0]  D_UU_AMIGA;
  wire  [7:0]  D_UM_AMIGA;
  wire  [6:0]  REG_ADDR;
  wire  [15:0] REG_WDATA;
  wire  [1:0]  REG_BE;
  wire         REG_WE;
  wire         REG_RD;
  logic [15:0] REG_RDATA;
  logic        REG_ACK;
  logic        REG_BUSY;

  logic [15:0] tb_d;
  logic        tb_d_oe;

  pullup (TACKn);
  pullup (TEAn);
  pullup (TBIn);

  assign D_UU_AMIGA = tb_d_oe ? tb_d[15:8] : 8'bz;
  assign D_UM_AMIGA = tb_d_oe ? tb_d[7:0]  : 8'bz;

  u111_word_port_target #(
    .ADDR_W(7), .TIMEOUT_CYCLES(T), .RO_BASE(7'h60)
  ) dut (
    .CLK40(CLK40), .RESETn(RESETn), .TSn(TSn), .SEL(SEL),
    .RnW(RnW), .SIZ(SIZ), .A_AMIGA(A_AMIGA), .PORTSIZE(PORTSIZE),
    .TACKn(TACKn), .TEAn(TEAn), .TBIn(TBIn),
    .D_UU_AMIGA(D_UU_AMIGA), .D_UM_AMIGA(D_UM_AMIGA),
    .REG_ADDR(REG_ADDR), .REG_WDATA(REG_WDATA), .REG_BE(REG_BE),
    .REG_WE(REG_WE), .REG_RD(REG_RD), .REG_RDATA(REG_RDATA),
    .REG_ACK(REG_ACK), .REG_BUSY(REG_BUSY)
  );

  always #12.5 CLK40 = ~CLK40;

  typedef struct {
    logic [1:0]  term;
    int          cyc;
    logic        rnw;
    logic [15:0] data;
  } sb_t;

  typedef struct {
    logic        rnw;
    logic [6:0]  idx;
    logic [1:0]  be;
    logic [15:0] wd;
  } st_t;

  sb_t sb_q[$];
  st_t st_q[$];

  logic [15:0] model_mem [128];
  logic [15:0] bk_mem [128];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int bk_delay = 0;

  always @(posedge CLK40) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // backend model: register file with programmable ACK delay
  initial begin : backend
    st_t s;
    logic [15:0] m;
    bit ack_pend;
    int ack_wait;
    ack_pend = 0;
    ack_wait = 0;
    REG_ACK = 1'b0;
    REG_RDATA = '0;
    forever begin
      @(negedge CLK40);
      REG_ACK = 1'b0;
      if (ack_pend) begin
        if (ack_wait == 0) begin
          REG_ACK = 1'b1;
          ack_pend = 0;
        end else ack_wait--;
      end
      if (!RESETn) ack_pend = 0;
      if (REG_RD === 1'b1 || REG_WE === 1'b1) begin
        if (st_q.size() == 0) begin
          chk("strobe_expected", 32'({REG_RD, REG_WE}), 32'd0);
        end else begin
          s = st_q.pop_front();
          chk("strobe_kind", 32'({REG_RD, REG_WE}),
              32'({s.rnw, !s.rnw}));
          chk("reg_addr", 32'(REG_ADDR), 32'(s.idx));
          chk("reg_be", 32'(REG_BE), 32'(s.be));
          if (!s.rnw) begin
            m = {{8{s.be[1]}}, {8{s.be[0]}}};
            chk("reg_wdata", 32'(REG_WDATA & m), 32'(s.wd & m));
            bk_mem[REG_ADDR] = (bk_mem[REG_ADDR] & ~m) | (REG_WDATA & m);
          end
          REG_RDATA = bk_mem[REG_ADDR];
          if (bk_delay < 200) begin
            ack_pend = 1;
            ack_wait = bk_delay;
          end
        end
      end
    end
  end

  // bus monitor: every termination is matched against the scoreboard
  initial begin : monitor
    sb_t e;
    forever begin
      @(negedge CLK40);
      if (TACKn === 1'b0 || TEAn === 1'b0) begin
        if (sb_q.size() == 0) begin
          chk("term_expected", 32'({TACKn, TEAn}), 32'd3);
        end else begin
          e = sb_q.pop_front();
          chk("term_type", 32'({TACKn, TEAn}), 32'(e.term));
          chk("term_cycle", cyc, e.cyc);
          chk("term_tbin", 32'(TBIn), 32'd0);
          chk("portsize", 32'(PORTSIZE), 32'd1);
          if (e.rnw && e.term == 2'b01)
            chk("rdata", 32'({D_UU_AMIGA, D_UM_AMIGA}), 32'(e.data));
          @(negedge CLK40);
          chk("recover_bus", 32'({TACKn, TEAn, TBIn}), 32'd7);
          if (e.rnw && e.term == 2'b01)
            chk("rdata_hold", 32'({D_UU_AMIGA, D_UM_AMIGA}), 32'(e.data));
          done_cnt++;
        end
      end
    end
  end

  task automatic xfer(input logic rnw, input logic [1:0] siz,
                      input logic [7:0] addr, input logic [15:0] wd,
                      input int d, input logic busy, input logic stray);
    logic [6:0]  idx;
    logic [1:0]  be;
    logic [15:0] m;
    logic        err;
    logic        rty;
    sb_t         e;
    st_t         s;
    int          lat;
    int          tgt;
    idx = addr[7:1];
    be  = (siz == 2'b01) ? (addr[0] ? 2'b01 : 2'b10) : 2'b11;
    m   = {{8{be[1]}}, {8{be[0]}}};
    err = (!rnw && idx >= 7'h60) ||
          ((siz == 2'b00 || siz == 2'b11) && addr[0]);
    rty = 1'b0;
`ifdef U111_TARGET_RETRY_EN
    rty = busy && !err;
`endif
    e.rnw  = rnw;
    e.data = model_mem[idx];
    if (err) begin
      e.term = 2'b10;
      lat = 2;
    end else if (rty) begin
      e.term = 2'b00;
      lat = 2;
    end else begin
      s.rnw = rnw; s.idx = idx; s.be = be; s.wd = wd;
      st_q.push_back(s);
      if (d <= T - 2) begin
        e.term = 2'b01;
        lat = 3 + d;
      end else begin
        e.term = 2'b10;
        lat = T + 1;
      end
      if (!rnw) model_mem[idx] = (model_mem[idx] & ~m) | (wd & m);
    end
    @(negedge CLK40);
    e.cyc = cyc + lat;
    sb_q.push_back(e);
    tgt = done_cnt + 1;
    bk_delay = d;
    REG_BUSY = busy;
    TSn = 1'b0; SEL = 1'b1; RnW = rnw; SIZ = siz; A_AMIGA = addr;
    tb_d = wd; tb_d_oe = !rnw;
    @(negedge CLK40);
    TSn = 1'b1;
    tb_d_oe = 1'b0;
    if (stray) begin
      @(negedge CLK40);
      TSn = 1'b0;
      RnW = 1'($urandom);
      SIZ = 2'($urandom);
      A_AMIGA = 8'($urandom);
      @(negedge CLK40);
      TSn = 1'b1;
    end
    for (int i = 0; i < T + 8 && done_cnt < tgt; i++) @(negedge CLK40);
    chk("xfer_done", 32'(done_cnt >= tgt), 32'd1);
    SEL = 1'b0;
    REG_BUSY = 1'b0;
  endtask

  task automatic unselected_ts();
    @(negedge CLK40);
    TSn = 1'b0; SEL = 1'b0; RnW = 1'b0; A_AMIGA = 8'($urandom);
    chk("portsize_unsel", 32'(PORTSIZE), 32'd0);
    @(negedge CLK40);
    TSn = 1'b1;
    repeat (3) @(negedge CLK40);
  endtask

  task automatic reset_mid();
    st_t s;
    s.rnw = 1'b1; s.idx = 7'h03; s.be = 2'b11; s.wd = '0;
    st_q.push_back(s);
    @(negedge CLK40);
    bk_delay = 255;
    TSn = 1'b0; SEL = 1'b1; RnW = 1'b1; SIZ = 2'b10; A_AMIGA = 8'h06;
    tb_d_oe = 1'b0;
    @(negedge CLK40);
    TSn = 1'b1;
    @(negedge CLK40);
    chk("access_tbin", 32'(TBIn), 32'd0);
    chk("access_tack", 32'(TACKn), 32'd1);
    RESETn = 1'b0;
    @(negedge CLK40);
    chk("rst_bus_released", 32'({TACKn, TEAn, TBIn}), 32'd7);
    chk("rst_strobes", 32'({REG_RD, REG_WE}), 32'd0);
    RESETn = 1'b1;
    SEL = 1'b0;
    @(negedge CLK40);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int r;
    int d;
    logic [15:0] v;
    RESETn = 1'b0; TSn = 1'b1; SEL = 1'b0; RnW = 1'b1;
    SIZ = 2'b10; A_AMIGA = '0; REG_BUSY = 1'b0;
    tb_d = '0; tb_d_oe = 1'b0;
    for (int i = 0; i < 128; i++) begin
      v = 16'($urandom);
      model_mem[i] = v;
      bk_mem[i] = v;
    end
    model_mem[5] = 16'hBEEF;
    bk_mem[5] = 16'hBEEF;
    repeat (4) @(negedge CLK40);
    RESETn = 1'b1;
    @(negedge CLK40);
    chk("reset_bus", 32'({TACKn, TEAn, TBIn}), 32'd7);
    chk("reset_strobes", 32'({REG_RD, REG_WE}), 32'd0);
    chk("reset_portsize", 32'(PORTSIZE), 32'd0);

    xfer(1'b1, 2'b10, 8'h0A, 16'h0000, 2, 1'b0, 1'b0);
    xfer(1'b0, 2'b01, 8'h0B, 16'h335A, 1, 1'b0, 1'b0);
    xfer(1'b0, 2'b10, 8'hC2, 16'h1234, 0, 1'b0, 1'b0);
    xfer(1'b1, 2'b10, 8'h10, 16'h0000, 255, 1'b0, 1'b0);
    reset_mid();
    xfer(1'b1, 2'b10, 8'h0A, 16'h0000, 0, 1'b0, 1'b0);
    xfer(1'b1, 2'b00, 8'h21, 16'h0000, 0, 1'b0, 1'b0);
    xfer(1'b1, 2'b11, 8'h20, 16'h0000, 1, 1'b0, 1'b0);
    xfer(1'b0, 2'b01, 8'h14, 16'hA7C3, 0, 1'b0, 1'b0);
    xfer(1'b1, 2'b10, 8'h14, 16'h0000, T - 2, 1'b0, 1'b0);
    xfer(1'b1, 2'b10, 8'h16, 16'h0000, T - 1, 1'b0, 1'b0);
    xfer(1'b0, 2'b10, 8'hBE, 16'h6789, 0, 1'b0, 1'b0);
    xfer(1'b1, 2'b10, 8'hC2, 16'h0000, 0, 1'b0, 1'b0);
    xfer(1'b0, 2'b10, 8'h08, 16'h4321, 0, 1'b1, 1'b0);
    xfer(1'b1, 2'b10, 8'h08, 16'h0000, 0, 1'b0, 1'b1);
    unselected_ts();

    for (int i = 0; i < 70; i++) begin
      r = $urandom_range(0, 19);
      d = (r == 0) ? 255 : (r == 1) ? T - 1 : (r == 2) ? T - 2 :
          $urandom_range(0, 3);
      xfer(1'($urandom), 2'($urandom), 8'($urandom), 16'($urandom),
           d, 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 4) == 0) unselected_ts();
    end

    repeat (5) @(negedge CLK40);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("strobe_q_empty", 32'(st_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
